mem_stage: RTL

- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Registers execute-stage results and runs a req/ack handshake with data memory for loads and stores.
- Stalls upstream while an access is outstanding.
- Delivers one registered writeback record per instruction to the writeback stage and forwarding unit.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/dm_handshake.sv | 111 +++++++++++
 rtl/mem_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and defaults for the pipeline memory stage.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [0:0] {
        MEM_IDLE   = 1'b0,
        MEM_ACCESS = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [REG_W_DEF-1:0]  reg_dest;
        logic                  reg_wr;
    } wb_rec_t;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/dm_handshake.sv
`default_nettype none
// ============================================================================
// Module   : dm_handshake
// Brief    : Data-memory req/ack sequencer for the memory stage. Owns the
//            ACCESS state machine, the dm_* output registers and, when
//            MEM_TIMEOUT_EN is defined, the wait counter and sticky err flag.
// Revision : 1.0 - initial release
// ============================================================================
module dm_handshake
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    output logic              idle,
    output logic              done,
    output logic              done_ok,
    output logic [DATA_W-1:0] done_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              err
);

    mem_state_t r_state;
    logic       w_ack;
    logic       w_tmo;

    // ack only counts while a request is actually outstanding
    assign w_ack     = (r_state == MEM_ACCESS) && dm_ack;
    assign idle      = (r_state == MEM_IDLE);
    assign done      = w_ack | w_tmo;
    assign done_ok   = w_ack;
    assign done_data = (w_ack && !dm_we) ? dm_rdata : '0;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_err;

    // give up once the wait counter would reach TIMEOUT on this edge
    assign w_tmo = (r_state == MEM_ACCESS) && !dm_ack && (r_wait == 8'(TIMEOUT - 1));
    assign err   = r_err;

    // wait-cycle counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= 8'd0;
            r_err  <= 1'b0;
        end else begin
            if (start && idle) begin
                r_wait <= 8'd0;
            end else if ((r_state == MEM_ACCESS) && !dm_ack) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    logic [7:0] w_unused_timeout;

    assign w_unused_timeout = 8'(TIMEOUT);
    assign w_tmo            = 1'b0;
    assign err              = 1'b0;
`endif

    // ACCESS FSM: request fields are frozen from launch until completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= MEM_IDLE;
            dm_req   <= 1'b0;
            dm_we    <= 1'b0;
            dm_addr  <= '0;
            dm_wdata <= '0;
        end else begin
            case (r_state)
                MEM_IDLE: begin
                    if (start) begin
                        r_state  <= MEM_ACCESS;
                        dm_req   <= 1'b1;
                        dm_we    <= start_we;
                        dm_addr  <= start_addr;
                        dm_wdata <= start_wdata;
                    end
                end
                MEM_ACCESS: begin
                    if (done) begin
                        r_state <= MEM_IDLE;
                        dm_req  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= MEM_IDLE;
                    dm_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule : dm_handshake
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage. Accepts execute results, runs data-memory
//            loads/stores through dm_handshake and emits one registered
//            writeback record per instruction. Optional timeout via the
//            MEM_TIMEOUT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [REG_W-1:0]  reg_dest_in,
    input  logic              mem_wr_in,
    input  logic              wb_sel_in,
    input  logic              reg_wr_in,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_reg_dest,
    output logic              wb_reg_wr,
    output logic              err
);

    logic              w_idle;
    logic              w_accept;
    logic              w_is_mem;
    logic              w_start;
    logic              w_done;
    logic              w_done_ok;
    logic [DATA_W-1:0] w_done_data;
    logic [REG_W-1:0]  r_pend_dest;
    logic              r_pend_wr;

    assign ex_ready = w_idle;
    assign w_accept = ex_valid && ex_ready;
    assign w_is_mem = mem_wr_in | wb_sel_in;
    assign w_start  = w_accept && w_is_mem;

    dm_handshake #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dm_handshake (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (w_start),
        .start_we    (mem_wr_in),
        .start_addr  (mem_addr),
        .start_wdata (mem_data),
        .idle        (w_idle),
        .done        (w_done),
        .done_ok     (w_done_ok),
        .done_data   (w_done_data),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_ack      (dm_ack),
        .dm_rdata    (dm_rdata),
        .err         (err)
    );

    // destination of the in-flight memory op; stores never write registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_dest <= '0;
            r_pend_wr   <= 1'b0;
        end else if (w_start) begin
            r_pend_dest <= reg_dest_in;
            r_pend_wr   <= reg_wr_in & ~mem_wr_in;
        end
    end

    // writeback record: one-cycle valid pulse, fields hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_data     <= '0;
            wb_reg_dest <= '0;
            wb_reg_wr   <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (w_accept && !w_is_mem) begin
                wb_valid    <= 1'b1;
                wb_data     <= alu_out;
                wb_reg_dest <= reg_dest_in;
                wb_reg_wr   <= reg_wr_in;
            end else if (w_done) begin
                wb_valid    <= 1'b1;
                wb_data     <= w_done_data;
                wb_reg_dest <= r_pend_dest;
                wb_reg_wr   <= r_pend_wr & w_done_ok;
            end
        end
    end

endmodule : mem_stage
`default_nettype wire
